// File: rtl/mpadd_seq.sv
// mpadd_seq -- multi-precision add/subtract sequencer.
//
// Adds or subtracts two NBYTES-wide operands with a single 8-bit
// ripple-carry byte adder. One byte pair is processed per clock, LSB byte
// first, and the carry moves between bytes through a register. A one-cycle
// done pulse marks the cycle where sum/cout hold the final result.
//
// Ports:
//   clk    in   1  system clock, rising edge
//   rst    in   1  asynchronous active-high reset
//   start  in   1  begin an operation (sampled in IDLE only)
//   sub    in   1  0 = a+b, 1 = a-b (latched with start)
//   a_in   in   W  operand A (latched with start)
//   b_in   in   W  operand B (latched with start)
//   busy   out  1  operation in progress (RUN and DONE)
//   done   out  1  one-cycle pulse, sum/cout valid
//   sum    out  W  result register
//   cout   out  1  carry out of MSB byte (sub: 1 = no borrow)
module mpadd_seq #(
  parameter  int NBYTES = 4,
  localparam int W      = 8 * NBYTES
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         sub,
  input  logic [W-1:0] a_in,
  input  logic [W-1:0] b_in,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] sum,
  output logic         cout
);

  // A one-bit index is kept even for NBYTES=1 so the register is never empty.
  localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t         state_q, state_d;
  logic [IW-1:0]  idx_q, idx_d;
  logic           carry_q, carry_d;
  logic           sub_q, sub_d;
  logic [W-1:0]   a_q, a_d;
  logic [W-1:0]   b_q, b_d;
  logic [W-1:0]   sum_q, sum_d;
  logic           cout_q, cout_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;

  // Byte adder operands and ripple chain.
  logic [7:0] add_a, b_raw, add_b, add_s;
  logic [8:0] add_c;

  // Select the current byte pair.
  always_comb begin
    add_a = '0;
    b_raw = '0;
    for (int i = 0; i < NBYTES; i++) begin
      if (idx_q == IW'(i)) begin
        add_a = a_q[8*i +: 8];
        b_raw = b_q[8*i +: 8];
      end
    end
  end

  // Subtract is invert-B plus carry-in 1; the carry-in comes from carry_q,
  // which is preloaded with sub at start.
  assign add_b    = b_raw ^ {8{sub_q}};
  assign add_c[0] = carry_q;

  for (genvar gi = 0; gi < 8; gi++) begin : g_fa
    assign add_s[gi]   = add_a[gi] ^ add_b[gi] ^ add_c[gi];
    assign add_c[gi+1] = (add_a[gi] & add_b[gi]) | (add_c[gi] & (add_a[gi] ^ add_b[gi]));
  end

  // Next-state logic. busy/done are computed for the next state so that the
  // outputs come straight from flops.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    sub_d   = sub_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a_in;
          b_d     = b_in;
          sub_d   = sub;
          sum_d   = '0;
          carry_d = sub;
          idx_d   = '0;
          state_d = RUN;
          busy_d  = 1'b1;
        end
      end
      RUN: begin
        busy_d = 1'b1;
        for (int i = 0; i < NBYTES; i++) begin
          if (idx_q == IW'(i)) sum_d[8*i +: 8] = add_s;
        end
        carry_d = add_c[8];
        idx_d   = idx_q + IW'(1);
        if (idx_q == IW'(NBYTES - 1)) begin
          cout_d  = add_c[8];
          state_d = DONE;
          done_d  = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      sub_q   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      sub_q   <= sub_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_mpadd_seq.sv
// Testbench for mpadd_seq: directed vectors on a 4-byte and a 1-byte instance.
module tb_mpadd_seq;

  logic        clk = 1'b0;
  logic        rst;

  logic        start4, sub4;
  logic [31:0] a_in4, b_in4, sum4;
  logic        busy4, done4, cout4;

  logic        start1, sub1;
  logic [7:0]  a_in1, b_in1, sum1;
  logic        busy1, done1, cout1;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  mpadd_seq #(.NBYTES(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .sub(sub4),
    .a_in(a_in4), .b_in(b_in4),
    .busy(busy4), .done(done4), .sum(sum4), .cout(cout4)
  );

  mpadd_seq #(.NBYTES(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .sub(sub1),
    .a_in(a_in1), .b_in(b_in1),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end else begin
      $display("ok   %s: %h", tag, obs);
    end
  endtask

  // One operation on the 4-byte instance; watches 8 cycles after acceptance.
  task automatic do_op4(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic s, input logic [31:0] es, input logic ec);
    int dcyc = 0;
    int dcnt = 0;
    int bcnt = 0;
    logic [31:0] rs = '0;
    logic rc = 1'b0;
    @(negedge clk);
    a_in4 = a; b_in4 = b; sub4 = s; start4 = 1'b1;
    @(posedge clk);               // acceptance edge 0
    #1 start4 = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);             // cycle k
      if (busy4) bcnt++;
      if (done4) begin
        dcnt++;
        dcyc = k;
        rs = sum4;
        rc = cout4;
      end
    end
    check_val({tag, "_sum"},      rs,       es);
    check_val({tag, "_cout"},     32'(rc),  32'(ec));
    check_val({tag, "_done_cyc"}, dcyc,     5);
    check_val({tag, "_done_cnt"}, dcnt,     1);
    check_val({tag, "_busy_cnt"}, bcnt,     5);
    check_val({tag, "_hold"},     sum4,     es);
  endtask

  function automatic logic [31:0] hs_a(input int n);
    return 32'h9E37_79B9 * 32'(n + 1);
  endfunction

  function automatic logic [31:0] hs_b(input int n);
    return 32'h7F4A_7C15 * 32'(n + 3);
  endfunction

  initial begin
    rst = 1'b1;
    start4 = 1'b0; sub4 = 1'b0; a_in4 = '0; b_in4 = '0;
    start1 = 1'b0; sub1 = 1'b0; a_in1 = '0; b_in1 = '0;
    #12;
    check_val("rst_busy4", 32'(busy4), 0);
    check_val("rst_done4", 32'(done4), 0);
    check_val("rst_sum4",  sum4,        0);
    check_val("rst_cout4", 32'(cout4), 0);
    check_val("rst_busy1", 32'(busy1), 0);
    @(negedge clk);
    rst = 1'b0;

    // Carry propagation and subtract cases.
    do_op4("add_ff_01",   32'h0000_00FF, 32'h0000_0001, 1'b0, 32'h0000_0100, 1'b0);
    do_op4("add_ripple",  32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1);
    do_op4("add_mixed",   32'h1234_5678, 32'h1111_1111, 1'b0, 32'h2345_6789, 1'b0);
    do_op4("sub_noborr",  32'h0000_0100, 32'h0000_0001, 1'b1, 32'h0000_00FF, 1'b1);
    do_op4("sub_equal",   32'hA5A5_A5A5, 32'hA5A5_A5A5, 1'b1, 32'h0000_0000, 1'b1);
    do_op4("sub_borrow",  32'h0000_0001, 32'h0000_0002, 1'b1, 32'hFFFF_FFFF, 1'b0);

    // start held high for 20 edges with operands changing every cycle:
    // acceptances expected at edges 0, 6, 12, 18, done 4 edges later.
    @(negedge clk);
    for (int n = 0; n < 26; n++) begin
      int m;
      logic expd;
      logic [32:0] full;
      start4 = (n < 20);
      a_in4  = hs_a(n);
      b_in4  = hs_b(n);
      sub4   = n[2];
      @(negedge clk);             // after edge n
      m = n - 4;
      expd = (m >= 0) && (m <= 18) && (m % 6 == 0);
      check_val($sformatf("hs_done_%0d", n), 32'(done4), 32'(expd));
      if (expd) begin
        if (m[2]) full = {1'b0, hs_a(m)} + {1'b0, ~hs_b(m)} + 33'd1;
        else      full = {1'b0, hs_a(m)} + {1'b0, hs_b(m)};
        check_val($sformatf("hs_sum_%0d", m),  sum4,         full[31:0]);
        check_val($sformatf("hs_cout_%0d", m), 32'(cout4),  32'(full[32]));
      end
    end
    start4 = 1'b0;

    // Reset in RUN cycle 2, between clock edges.
    @(negedge clk);
    a_in4 = 32'h1234_5678; b_in4 = 32'h1111_1111; sub4 = 1'b0; start4 = 1'b1;
    @(posedge clk);               // edge 0
    #1 start4 = 1'b0;
    @(posedge clk);               // edge 1: byte 0 written
    #2;
    check_val("mid_partial", sum4, 32'h0000_0089);
    rst = 1'b1;
    #1;
    check_val("mid_rst_busy", 32'(busy4), 0);
    check_val("mid_rst_done", 32'(done4), 0);
    check_val("mid_rst_sum",  sum4,        0);
    check_val("mid_rst_cout", 32'(cout4), 0);
    @(negedge clk);
    rst = 1'b0;
    begin
      int dseen = 0;
      for (int k = 0; k < 8; k++) begin
        @(negedge clk);
        if (done4) dseen++;
      end
      check_val("mid_no_done", dseen, 0);
    end
    do_op4("rst_recover", 32'h0000_0003, 32'h0000_0004, 1'b0, 32'h0000_0007, 1'b0);

    // Single-byte instance: 0xFF + 0x01.
    begin
      int dcyc = 0;
      int dcnt = 0;
      int bcnt = 0;
      logic [7:0] rs = '0;
      logic rc = 1'b0;
      @(negedge clk);
      a_in1 = 8'hFF; b_in1 = 8'h01; sub1 = 1'b0; start1 = 1'b1;
      @(posedge clk);
      #1 start1 = 1'b0;
      for (int k = 1; k <= 5; k++) begin
        @(negedge clk);
        if (busy1) bcnt++;
        if (done1) begin
          dcnt++;
          dcyc = k;
          rs = sum1;
          rc = cout1;
        end
      end
      check_val("n1_sum",      32'(rs), 32'h00);
      check_val("n1_cout",     32'(rc), 1);
      check_val("n1_done_cyc", dcyc,     2);
      check_val("n1_done_cnt", dcnt,     1);
      check_val("n1_busy_cnt", bcnt,     2);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
